minimac2_rx_writer: RTL and testbench
=====================================

// Module: minimac2_rx_writer
// PURPOSE
// - MII receive front end of minimac2, clocked by phy_rx_clk; sits directly upstream of minimac2_memory.
// - Hunts preamble/SFD, assembles nibbles into bytes, and writes frames into the two 2 KiB RX slot buffers (rxb0/rxb1 ports).
// - Slot ownership comes from slot-armed levels already synchronised into this domain.
// - Reports per-slot completion and byte counts, and flags aborted frames.
// PARAMETERS
// - ADR_W  11  slot buffer address width; slot depth = 2**ADR_W bytes.
// PORTS
// - phy_rx_clk    in   1      sole clock (MII RX clock, 2.5/25 MHz)
// - sys_rst       in   1      reset, asynchronous, active-low
// - phy_rx_data   in   4      MII RXD nibble
// - phy_dv        in   1      MII RX_DV
// - phy_rx_er     in   1      MII RX_ER
// - rx_ready0/1   in   1      slot 0/1 armed by software (level, pre-synchronised)
// - rxb0_dat/rxb1_dat    out  8      write byte to slot 0/1
// - rxb0_adr/rxb1_adr    out  ADR_W  write address to slot 0/1
// - rxb0_we/rxb1_we      out  1      write strobe to slot 0/1
// - rx_done0/1   out  1      1-cycle pulse: good frame complete in slot 0/1
// - rx_count0/1  out  ADR_W+1  byte count of last completed frame in slot 0/1
// - rx_abort     out  1      1-cycle pulse: frame dropped (no slot, RX_ER, or overflow)
// BEHAVIOUR
// - Reset (sys_rst=0, async): state IDLE; all outputs 0; last_slot=1, so slot 0 is preferred first.
// - All outputs are registered. The nibble sampled while phy_dv=1 is the input data.
// - States:
//   - IDLE: phy_dv=1 -> HUNT.
//   - HUNT: nibble 0x5 then 0xD on consecutive cycles (SFD) -> pick slot.
//     - Pick slot 0 if rx_ready0 and (last_slot==1 or !rx_ready1); else slot 1 if rx_ready1; else DROP.
//     - phy_dv=0 in HUNT -> IDLE, no pulse.
//   - RECV: low nibble first.
//     - Cycle N samples high nibble -> cycle N+1: rxbS_we=1, rxbS_dat={hi,lo}, rxbS_adr=byte index.
//     - Index starts at 0 and increments after each write. The other slot's we stays 0.
//   - DROP: ignore nibbles until phy_dv=0 -> IDLE.
// - End of frame (phy_dv falls in RECV):
//   - Next cycle: rx_doneS=1 for 1 cycle, rx_countS=bytes written, last_slot=S.
//   - A trailing odd nibble is discarded and not counted.
//   - Zero-byte frame: no done, rx_abort=1.
// - Boundaries:
//   - phy_rx_er=1 during RECV -> rx_abort pulse next cycle, -> DROP; no done; rx_countS unchanged.
//   - Byte number 2**ADR_W+1 would be written (overflow) -> no write, rx_abort pulse, -> DROP. Exactly 2**ADR_W bytes is legal: count=2048.
//   - rx_readyS deasserting mid-frame does not abort (ownership is latched at SFD).
//   - rx_countS holds until the next done on that slot.
//   - phy_dv rising again the cycle after a done: accepted (IDLE->HUNT).
//   - Reset mid-frame: writes stop immediately, no done/abort, next frame needs fresh SFD.
// STRUCTURE
// - Shared minimac2 defines include: SFD nibbles (4'h5, 4'hD) and RX state encodings IDLE/HUNT/RECV/DROP.
// - Single module; no sub-module. The nibble assembler is a 4-bit holding register plus phase bit.
// TESTING
// - 7x 0x55 preamble, SFD, 64 bytes 00..3F, both slots armed -> rxb0 writes adr 0..63, data 00..3F; rx_done0 once; rx_count0=64.
// - Second identical frame, both armed -> goes to slot 1 (round-robin): rx_done1, rx_count1=64; rx_count0 still 64.
// - Neither slot armed -> no rxb*_we, rx_abort pulse at SFD-time drop, no done; next frame with rx_ready1 -> slot 1.
// - phy_rx_er at byte 10 -> 10 writes, rx_abort 1 cycle, no done; rx_count unchanged.
// - 2048-byte frame -> count=2048, done. 2049-byte frame -> 2048 writes, abort, no done.
// - Odd nibble: 5 bytes + 1 nibble -> count=5. Async reset asserted mid-frame -> outputs 0 immediately, no pulses after release.

Source files
------------

// File: rtl/minimac2_rx_writer_pkg.sv
// Shared minimac2 RX definitions: SFD nibbles, RX state encodings and slot arbitration.
package minimac2_rx_writer_pkg;

  localparam logic [3:0] SFD_NIB0 = 4'h5;
  localparam logic [3:0] SFD_NIB1 = 4'hD;

  localparam logic [1:0] RX_IDLE = 2'd0;
  localparam logic [1:0] RX_HUNT = 2'd1;
  localparam logic [1:0] RX_RECV = 2'd2;
  localparam logic [1:0] RX_DROP = 2'd3;

  // Returns {drop, slot}; slot 0 wins ties unless it was the last slot used.
  function automatic logic [1:0] pick_slot(input logic ready0, input logic ready1,
                                           input logic last_slot);
    logic [1:0] res;
    if (ready0 && (last_slot || !ready1)) begin
      res = 2'b00;
    end else if (ready1) begin
      res = 2'b01;
    end else begin
      res = 2'b10;
    end
    return res;
  endfunction

endpackage

// File: rtl/minimac2_rx_writer.sv
// MII receive front end: finds preamble/SFD, assembles nibbles into bytes and
// writes frames into whichever of the two armed RX slot buffers is next in turn.
module minimac2_rx_writer #(
  parameter int ADR_W = 11
) (
  input  logic             phy_rx_clk,
  input  logic             sys_rst,
  input  logic [3:0]       phy_rx_data,
  input  logic             phy_dv,
  input  logic             phy_rx_er,
  input  logic             rx_ready0,
  input  logic             rx_ready1,
  output logic [7:0]       rxb0_dat,
  output logic [ADR_W-1:0] rxb0_adr,
  output logic             rxb0_we,
  output logic [7:0]       rxb1_dat,
  output logic [ADR_W-1:0] rxb1_adr,
  output logic             rxb1_we,
  output logic             rx_done0,
  output logic             rx_done1,
  output logic [ADR_W:0]   rx_count0,
  output logic [ADR_W:0]   rx_count1,
  output logic             rx_abort
);
  import minimac2_rx_writer_pkg::*;

  localparam logic [ADR_W:0] SLOT_DEPTH = {1'b1, {ADR_W{1'b0}}};

  logic [1:0]       r_state;
  logic             r_saw5;
  logic             r_slot;
  logic             r_last_slot;
  logic             r_phase;
  logic [3:0]       r_lo;
  logic [ADR_W:0]   r_idx;
  logic [7:0]       r_rxb0_dat;
  logic [ADR_W-1:0] r_rxb0_adr;
  logic             r_rxb0_we;
  logic [7:0]       r_rxb1_dat;
  logic [ADR_W-1:0] r_rxb1_adr;
  logic             r_rxb1_we;
  logic             r_done0;
  logic             r_done1;
  logic [ADR_W:0]   r_count0;
  logic [ADR_W:0]   r_count1;
  logic             r_abort;
  logic [1:0]       w_pick;

  assign w_pick = pick_slot(rx_ready0, rx_ready1, r_last_slot);

  // Receive state machine, nibble assembler and registered slot write port.
  always_ff @(posedge phy_rx_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_state     <= RX_IDLE;
      r_saw5      <= 1'b0;
      r_slot      <= 1'b0;
      r_last_slot <= 1'b1;
      r_phase     <= 1'b0;
      r_lo        <= 4'h0;
      r_idx       <= '0;
      r_rxb0_dat  <= 8'h00;
      r_rxb0_adr  <= '0;
      r_rxb0_we   <= 1'b0;
      r_rxb1_dat  <= 8'h00;
      r_rxb1_adr  <= '0;
      r_rxb1_we   <= 1'b0;
      r_done0     <= 1'b0;
      r_done1     <= 1'b0;
      r_count0    <= '0;
      r_count1    <= '0;
      r_abort     <= 1'b0;
    end else begin
      r_rxb0_we <= 1'b0;
      r_rxb1_we <= 1'b0;
      r_done0   <= 1'b0;
      r_done1   <= 1'b0;
      r_abort   <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          if (phy_dv) begin
            r_state <= RX_HUNT;
            r_saw5  <= (phy_rx_data == SFD_NIB0);
          end
        end
        RX_HUNT: begin
          if (!phy_dv) begin
            r_state <= RX_IDLE;
          end else if (r_saw5 && (phy_rx_data == SFD_NIB1)) begin
            r_phase <= 1'b0;
            r_idx   <= '0;
            r_slot  <= w_pick[0];
            if (w_pick[1]) begin
              r_state <= RX_DROP;
              r_abort <= 1'b1;
            end else begin
              r_state <= RX_RECV;
            end
          end else begin
            r_saw5 <= (phy_rx_data == SFD_NIB0);
          end
        end
        RX_RECV: begin
          if (!phy_dv) begin
            // A dangling low nibble is simply never committed.
            r_state <= RX_IDLE;
            if (r_idx == '0) begin
              r_abort <= 1'b1;
            end else begin
              r_last_slot <= r_slot;
              if (r_slot) begin
                r_done1  <= 1'b1;
                r_count1 <= r_idx;
              end else begin
                r_done0  <= 1'b1;
                r_count0 <= r_idx;
              end
            end
          end else if (phy_rx_er) begin
            r_state <= RX_DROP;
            r_abort <= 1'b1;
          end else if (!r_phase) begin
            r_lo    <= phy_rx_data;
            r_phase <= 1'b1;
          end else if (r_idx == SLOT_DEPTH) begin
            r_state <= RX_DROP;
            r_abort <= 1'b1;
          end else begin
            r_phase <= 1'b0;
            r_idx   <= r_idx + {{ADR_W{1'b0}}, 1'b1};
            if (r_slot) begin
              r_rxb1_we  <= 1'b1;
              r_rxb1_dat <= {phy_rx_data, r_lo};
              r_rxb1_adr <= r_idx[ADR_W-1:0];
            end else begin
              r_rxb0_we  <= 1'b1;
              r_rxb0_dat <= {phy_rx_data, r_lo};
              r_rxb0_adr <= r_idx[ADR_W-1:0];
            end
          end
        end
        RX_DROP: begin
          if (!phy_dv) begin
            r_state <= RX_IDLE;
          end
        end
        default: begin
          r_state <= RX_IDLE;
        end
      endcase
    end
  end

  assign rxb0_dat  = r_rxb0_dat;
  assign rxb0_adr  = r_rxb0_adr;
  assign rxb0_we   = r_rxb0_we;
  assign rxb1_dat  = r_rxb1_dat;
  assign rxb1_adr  = r_rxb1_adr;
  assign rxb1_we   = r_rxb1_we;
  assign rx_done0  = r_done0;
  assign rx_done1  = r_done1;
  assign rx_count0 = r_count0;
  assign rx_count1 = r_count1;
  assign rx_abort  = r_abort;

endmodule

// File: tb/tb_minimac2_rx_writer.sv
// Scoreboard bench for minimac2_rx_writer: a frame-level model queues the expected
// writes/done/abort events and a free-running monitor pops them as the DUT emits them.
module tb_minimac2_rx_writer;

  localparam int ADR_W = 11;
  localparam int DEPTH = 2048;

  logic             phy_rx_clk = 1'b0;
  logic             sys_rst;
  logic [3:0]       phy_rx_data;
  logic             phy_dv;
  logic             phy_rx_er;
  logic             rx_ready0;
  logic             rx_ready1;
  logic [7:0]       rxb0_dat;
  logic [ADR_W-1:0] rxb0_adr;
  logic             rxb0_we;
  logic [7:0]       rxb1_dat;
  logic [ADR_W-1:0] rxb1_adr;
  logic             rxb1_we;
  logic             rx_done0;
  logic             rx_done1;
  logic [ADR_W:0]   rx_count0;
  logic [ADR_W:0]   rx_count1;
  logic             rx_abort;

  minimac2_rx_writer #(.ADR_W(ADR_W)) dut (
    .phy_rx_clk (phy_rx_clk),
    .sys_rst    (sys_rst),
    .phy_rx_data(phy_rx_data),
    .phy_dv     (phy_dv),
    .phy_rx_er  (phy_rx_er),
    .rx_ready0  (rx_ready0),
    .rx_ready1  (rx_ready1),
    .rxb0_dat   (rxb0_dat),
    .rxb0_adr   (rxb0_adr),
    .rxb0_we    (rxb0_we),
    .rxb1_dat   (rxb1_dat),
    .rxb1_adr   (rxb1_adr),
    .rxb1_we    (rxb1_we),
    .rx_done0   (rx_done0),
    .rx_done1   (rx_done1),
    .rx_count0  (rx_count0),
    .rx_count1  (rx_count1),
    .rx_abort   (rx_abort)
  );

  always #5 phy_rx_clk = ~phy_rx_clk;

  // kind: 0 = byte write, 1 = done (adr carries the count), 2 = abort
  typedef struct {
    int kind;
    int slot;
    int adr;
    int dat;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  m_last   = 1;
  int  m_cnt[2] = '{0, 0};

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input int slot, input int adr, input int dat);
    ev_t e;
    e.kind = kind; e.slot = slot; e.adr = adr; e.dat = dat;
    exp_q.push_back(e);
  endtask

  // Owner chosen at SFD: the slot not used last if armed, else the other one, else none.
  function automatic int model_pick(input bit r0, input bit r1);
    bit rdy[2];
    int pref;
    rdy[0] = r0; rdy[1] = r1;
    pref = (m_last == 1) ? 0 : 1;
    if (rdy[pref]) return pref;
    if (rdy[1-pref]) return 1 - pref;
    return -1;
  endfunction

  task automatic drive(input logic [3:0] nib, input logic er);
    @(posedge phy_rx_clk); #1;
    phy_dv = 1'b1; phy_rx_data = nib; phy_rx_er = er;
  endtask

  task automatic send_frame(input int n, input bit odd, input int er_at, input bit rdy0,
                            input bit rdy1, input bit seq, input bit clr_mid, input int gap);
    int slot, wrote;
    bit live;
    logic [7:0] b;
    logic [3:0] nb;
    rx_ready0 = rdy0; rx_ready1 = rdy1;
    for (int i = 0; i < 15; i++) drive(4'h5, 1'b0);
    drive(4'hD, 1'b0);
    slot = model_pick(rdy0, rdy1);
    live = 1'b1; wrote = 0;
    if (slot < 0) begin
      push(2, 0, 0, 0); live = 1'b0; slot = 0;
    end
    for (int k = 0; k < n; k++) begin
      b = seq ? 8'(k) : 8'($urandom);
      drive(b[3:0], (k == er_at) ? 1'b1 : 1'b0);
      if (live && k == er_at) begin
        push(2, 0, 0, 0); live = 1'b0;
      end
      if (clr_mid && k == n / 2) rx_ready0 = 1'b0;
      drive(b[7:4], 1'b0);
      if (live) begin
        if (k >= DEPTH) begin
          push(2, 0, 0, 0); live = 1'b0;
        end else begin
          push(0, slot, k, int'(b)); wrote++;
        end
      end
    end
    if (odd) begin
      nb = 4'($urandom);
      drive(nb, 1'b0);
    end
    @(posedge phy_rx_clk); #1;
    phy_dv = 1'b0; phy_rx_data = 4'h0; phy_rx_er = 1'b0;
    if (live) begin
      if (wrote == 0) begin
        push(2, 0, 0, 0);
      end else begin
        push(1, slot, wrote, 0);
        m_cnt[slot] = wrote;
        m_last = slot;
      end
    end
    for (int g = 1; g < gap; g++) begin
      @(posedge phy_rx_clk); #1;
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(posedge phy_rx_clk);
    repeat (3) @(posedge phy_rx_clk);
    #1;
    chk({tag, "_pending"}, exp_q.size(), 0);
    exp_q.delete();
    chk({tag, "_count0"}, int'(rx_count0), m_cnt[0]);
    chk({tag, "_count1"}, int'(rx_count1), m_cnt[1]);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_we0"}, int'(rxb0_we), 0);
    chk({tag, "_we1"}, int'(rxb1_we), 0);
    chk({tag, "_done0"}, int'(rx_done0), 0);
    chk({tag, "_done1"}, int'(rx_done1), 0);
    chk({tag, "_abort"}, int'(rx_abort), 0);
    chk({tag, "_count0"}, int'(rx_count0), 0);
    chk({tag, "_count1"}, int'(rx_count1), 0);
    chk({tag, "_adr0"}, int'(rxb0_adr), 0);
    chk({tag, "_dat0"}, int'(rxb0_dat), 0);
  endtask

  // Monitor: every output event seen must match the head of the expected queue.
  initial begin
    ev_t o, e;
    int nev;
    forever begin
      @(negedge phy_rx_clk);
      if (sys_rst === 1'b1) begin
        nev = int'(rxb0_we) + int'(rxb1_we) + int'(rx_done0) + int'(rx_done1) + int'(rx_abort);
        if (nev > 1) begin
          chk("simultaneous_events", nev, 1);
        end else if (nev == 1) begin
          o.dat = 0;
          if (rxb0_we) begin
            o.kind = 0; o.slot = 0; o.adr = int'(rxb0_adr); o.dat = int'(rxb0_dat);
          end else if (rxb1_we) begin
            o.kind = 0; o.slot = 1; o.adr = int'(rxb1_adr); o.dat = int'(rxb1_dat);
          end else if (rx_done0) begin
            o.kind = 1; o.slot = 0; o.adr = int'(rx_count0);
          end else if (rx_done1) begin
            o.kind = 1; o.slot = 1; o.adr = int'(rx_count1);
          end else begin
            o.kind = 2; o.slot = 0; o.adr = 0;
          end
          if (exp_q.size() == 0) begin
            chk("unexpected_event_kind", o.kind, -1);
          end else begin
            e = exp_q.pop_front();
            chk("ev_kind", o.kind, e.kind);
            chk("ev_slot", o.slot, e.slot);
            chk("ev_adr_or_count", o.adr, e.adr);
            chk("ev_dat", o.dat, e.dat);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int slot;
    logic [7:0] b;
    sys_rst = 1'b0; phy_rx_data = 4'h0; phy_dv = 1'b0; phy_rx_er = 1'b0;
    rx_ready0 = 1'b0; rx_ready1 = 1'b0;
    #1;
    chk_zero("reset");
    repeat (3) @(posedge phy_rx_clk);
    #1 sys_rst = 1'b1;
    repeat (2) @(posedge phy_rx_clk);
    #1;

    // Sequential 64-byte frames alternate between slots.
    send_frame(64, 1'b0, -1, 1'b1, 1'b1, 1'b1, 1'b0, 2); drain("f1_slot0");
    send_frame(64, 1'b0, -1, 1'b1, 1'b1, 1'b1, 1'b0, 2); drain("f2_slot1");
    // No slot armed, then only slot 1 armed.
    send_frame(20, 1'b0, -1, 1'b0, 1'b0, 1'b0, 1'b0, 2); drain("noslot");
    send_frame(12, 1'b0, -1, 1'b0, 1'b1, 1'b0, 1'b0, 2); drain("only1");
    // RX_ER on byte 10.
    send_frame(30, 1'b0, 10, 1'b1, 1'b1, 1'b0, 1'b0, 2); drain("rxer");
    // Full slot, then one byte too many.
    send_frame(DEPTH, 1'b0, -1, 1'b1, 1'b1, 1'b0, 1'b0, 2); drain("full");
    send_frame(DEPTH + 1, 1'b0, -1, 1'b1, 1'b1, 1'b0, 1'b0, 2); drain("overflow");
    // Trailing nibble, empty frame, ready dropped mid-frame.
    send_frame(5, 1'b1, -1, 1'b1, 1'b1, 1'b0, 1'b0, 2); drain("oddnib");
    send_frame(0, 1'b0, -1, 1'b1, 1'b1, 1'b0, 1'b0, 2); drain("zerobyte");
    send_frame(0, 1'b1, -1, 1'b1, 1'b1, 1'b0, 1'b0, 2); drain("zerobyte_odd");
    send_frame(40, 1'b0, -1, 1'b1, 1'b0, 1'b0, 1'b1, 2); drain("readydrop");
    // Back-to-back frames with a single idle cycle.
    send_frame(8, 1'b0, -1, 1'b1, 1'b1, 1'b0, 1'b0, 1);
    send_frame(9, 1'b0, -1, 1'b1, 1'b1, 1'b0, 1'b0, 1);
    drain("backtoback");

    for (int r = 0; r < 14; r++) begin
      int n, er;
      n  = int'($urandom_range(0, 90));
      er = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 90)) : -1;
      send_frame(n, 1'($urandom_range(0, 1)), er, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'b0, 1'b0, int'($urandom_range(1, 4)));
      drain("random");
    end

    // Asynchronous reset in the middle of a frame.
    rx_ready0 = 1'b1; rx_ready1 = 1'b1;
    for (int i = 0; i < 15; i++) drive(4'h5, 1'b0);
    drive(4'hD, 1'b0);
    slot = model_pick(1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      b = 8'($urandom);
      drive(b[3:0], 1'b0);
      drive(b[7:4], 1'b0);
      push(0, slot, k, int'(b));
    end
    drive(4'h3, 1'b0);
    @(posedge phy_rx_clk); #3;
    sys_rst = 1'b0;
    #1;
    chk_zero("midreset");
    exp_q.delete();
    m_last = 1; m_cnt[0] = 0; m_cnt[1] = 0;
    phy_rx_data = 4'hA;
    repeat (3) @(posedge phy_rx_clk);
    #1 sys_rst = 1'b1;
    for (int i = 0; i < 6; i++) drive(4'hA, 1'b0);
    @(posedge phy_rx_clk); #1;
    phy_dv = 1'b0; phy_rx_data = 4'h0;
    drain("after_reset");
    send_frame(7, 1'b0, -1, 1'b1, 1'b1, 1'b0, 1'b0, 2); drain("post_reset_slot0");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
